// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer with architectural HI/LO.
// Sits beside the EX-stage ALU. It runs MULT/MULTU/DIV/DIVU over 32 iterations,
// stalls the front of the pipeline while busy, and then commits the result to HI/LO.
// It also services MTHI/MTLO and drives hiOut/loOut for MFHI/MFLO.
//
// Optional feature: `MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiplier for MULT/MULTU. Divides always use the iterative path.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   startE          EX instruction is a mul/div op
//   mdOpE[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcAE, srcBE    rs / rt operands
//   cancelE         abort an in-flight operation
//   mthiE, mtloE    write wdataE to HI / LO
//   wdataE          MTHI/MTLO data
//   stallMD         (combinational) freeze PC, IF/ID, ID/EX
//   mdDoneE         one-cycle pulse in the cycle after HI/LO commit
//   hiOut, loOut    HI / LO registers
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  mdOpE,
  input  logic [31:0] srcAE,
  input  logic [31:0] srcBE,
  input  logic        cancelE,
  input  logic        mthiE,
  input  logic        mtloE,
  input  logic [31:0] wdataE,
  output logic        stallMD,
  output logic        mdDoneE,
  output logic [31:0] hiOut,
  output logic [31:0] loOut
);

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned DWORD_WIDTH = 2 * WORD_WIDTH;
  localparam int unsigned CNT_WIDTH = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  stateT                   state, stateNext;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [DWORD_WIDTH-1:0]  work;
  logic [WORD_WIDTH-1:0]   opB;
  logic                    isDiv, signA, signB;

  logic loadOps, stepEn, commit, fastCommit, mthiWe, mtloWe;
  logic fastMulSel;

  // Operand magnitudes; unsigned ops keep the raw value
  logic                  signedOp;
  logic [WORD_WIDTH-1:0] magA, magB;
  assign signedOp = ~mdOpE[0];
  assign magA = (signedOp && srcAE[WORD_WIDTH-1]) ? -srcAE : srcAE;
  assign magB = (signedOp && srcBE[WORD_WIDTH-1]) ? -srcBE : srcBE;

  // Optional single-cycle multiplier
  logic [DWORD_WIDTH-1:0] fastProd;
`ifdef MULDIV_FAST_MUL_EN
  assign fastMulSel = 1'b1;
  always_comb begin
    if (mdOpE[0])
      fastProd = DWORD_WIDTH'({32'b0, srcAE} * {32'b0, srcBE});
    else
      fastProd = DWORD_WIDTH'($signed({{32{srcAE[31]}}, srcAE}) *
                              $signed({{32{srcBE[31]}}, srcBE}));
  end
`else
  assign fastMulSel = 1'b0;
  assign fastProd   = '0;
`endif

  // One iteration of shift-add multiply or restoring divide.
  // The multiply keeps {partial product, remaining multiplier}; the divide keeps {remainder, quotient}.
  logic [WORD_WIDTH:0]    mulSum;
  logic [WORD_WIDTH:0]    divPartial;
  logic [WORD_WIDTH+1:0]  divDiff;
  logic [DWORD_WIDTH-1:0] workStep;
  always_comb begin
    mulSum     = {1'b0, work[63:32]} + (work[0] ? {1'b0, opB} : 33'd0);
    divPartial = {work[63:32], work[31]};
    divDiff    = {1'b0, divPartial} - {2'b0, opB};
    if (isDiv) begin
      if (!divDiff[WORD_WIDTH+1])
        workStep = {divDiff[31:0], work[30:0], 1'b1};
      else
        workStep = {divPartial[31:0], work[30:0], 1'b0};
    end else begin
      workStep = {mulSum, work[31:1]};
    end
  end

  // Sign fix-up of the final iteration result
  logic [DWORD_WIDTH-1:0] prodSigned;
  logic [WORD_WIDTH-1:0]  resHi, resLo;
  always_comb begin
    prodSigned = (signA ^ signB) ? -workStep : workStep;
    resHi      = prodSigned[63:32];
    resLo      = prodSigned[31:0];
    if (isDiv) begin
      resLo = (signA ^ signB) ? -workStep[31:0] : workStep[31:0];
      // Zero divisor: the remainder path already reproduces srcAE
      if (opB == '0) resLo = '1;
      resHi = signA ? -workStep[63:32] : workStep[63:32];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and control decode
  always_comb begin
    stateNext  = state;
    stallMD    = 1'b0;
    loadOps    = 1'b0;
    stepEn     = 1'b0;
    commit     = 1'b0;
    fastCommit = 1'b0;
    mthiWe     = 1'b0;
    mtloWe     = 1'b0;
    case (state)
      IDLE: begin
        if (startE) begin
          stallMD = 1'b1;
          if (fastMulSel && !mdOpE[1]) begin
            fastCommit = 1'b1;
            stateNext  = DONE;
          end else begin
            loadOps   = 1'b1;
            stateNext = CALC;
          end
        end else begin
          mthiWe = mthiE;
          mtloWe = mtloE;
        end
      end
      CALC: begin
        stallMD = 1'b1;
        if (cancelE) begin
          stateNext = IDLE;
        end else begin
          stepEn = 1'b1;
          if (cnt == CNT_WIDTH'(31)) begin
            commit    = 1'b1;
            stateNext = DONE;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      work    <= '0;
      opB     <= '0;
      isDiv   <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      hiOut   <= '0;
      loOut   <= '0;
      mdDoneE <= 1'b0;
    end else begin
      mdDoneE <= commit | fastCommit;
      if (loadOps) begin
        cnt   <= '0;
        work  <= {32'b0, magA};
        opB   <= magB;
        isDiv <= mdOpE[1];
        signA <= signedOp & srcAE[WORD_WIDTH-1];
        signB <= signedOp & srcBE[WORD_WIDTH-1];
      end else if (stepEn) begin
        work <= workStep;
        cnt  <= cnt + CNT_WIDTH'(1);
      end
      if (commit) begin
        hiOut <= resHi;
        loOut <= resLo;
      end else if (fastCommit) begin
        hiOut <= fastProd[63:32];
        loOut <= fastProd[31:0];
      end else begin
        if (mthiWe) hiOut <= wdataE;
        if (mtloWe) loOut <= wdataE;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors for muldiv_ctrl, plus sequences for
// MTHI/MTLO, cancel and mid-operation reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [1:0]  mdOpE;
  logic [31:0] srcAE, srcBE;
  logic        cancelE, mthiE, mtloE;
  logic [31:0] wdataE;
  logic        stallMD, mdDoneE;
  logic [31:0] hiOut, loOut;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .startE(startE), .mdOpE(mdOpE),
    .srcAE(srcAE), .srcBE(srcBE), .cancelE(cancelE),
    .mthiE(mthiE), .mtloE(mtloE), .wdataE(wdataE),
    .stallMD(stallMD), .mdDoneE(mdDoneE), .hiOut(hiOut), .loOut(loOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vecT;

  vecT vecs[11];
  int  nVec = 0;
  int  nErr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one op with startE held until DONE, as the pipeline would.
  // It is entered and left 1 time unit after a rising edge.
  task automatic runVec(input vecT v, input int idx);
    int  stallCnt;
    int  expStall;
    bit  done;
    string tag;
    tag = $sformatf("vec%0d", idx);
`ifdef MULDIV_FAST_MUL_EN
    expStall = v.op[1] ? 33 : 1;
`else
    expStall = 33;
`endif
    stallCnt = 0;
    done     = 1'b0;
    mdOpE = v.op; srcAE = v.a; srcBE = v.b; startE = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (stallMD) stallCnt++;
      tick();
      if (mdDoneE) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stallCycles"}, 32'(stallCnt), 32'(expStall));
    #1;
    chk({tag, " stallInDone"}, 32'(stallMD), 32'd0);
    chk({tag, " hi"}, hiOut, v.hi);
    chk({tag, " lo"}, loOut, v.lo);
    startE = 1'b0;
    tick();
    chk({tag, " donePulseEnd"}, 32'(mdDoneE), 32'd0);
  endtask

  // Preload HI/LO, start DIVU 10/3, then cancel or reset at cycle 10.
  task automatic abortSeq(input bit useReset);
    string tag;
    int doneSeen;
    tag = useReset ? "rstSeq" : "cancelSeq";
    doneSeen = 0;
    mthiE = 1'b1; wdataE = 32'h0000_1234; tick();
    mthiE = 1'b0; mtloE = 1'b1; wdataE = 32'h0000_5678; tick();
    mtloE = 1'b0;
    chk({tag, " preHi"}, hiOut, 32'h0000_1234);
    chk({tag, " preLo"}, loOut, 32'h0000_5678);
    mdOpE = 2'b11; srcAE = 32'd10; srcBE = 32'd3; startE = 1'b1;
    for (int c = 0; c < 10; c++) begin
      // MTHI during a busy divide must be ignored
      mthiE  = (c == 5);
      wdataE = 32'hDEAD_BEEF;
      #1;
      if (mdDoneE) doneSeen++;
      tick();
    end
    mthiE = 1'b0;
    if (useReset) rst = 1'b1;
    else          cancelE = 1'b1;
    #1;
    chk({tag, " stallCycle10"}, 32'(stallMD), 32'd1);
    tick();
    rst = 1'b0; cancelE = 1'b0; startE = 1'b0;
    #1;
    chk({tag, " stallCycle11"}, 32'(stallMD), 32'd0);
    chk({tag, " hi"}, hiOut, useReset ? 32'h0 : 32'h0000_1234);
    chk({tag, " lo"}, loOut, useReset ? 32'h0 : 32'h0000_5678);
    for (int c = 0; c < 40; c++) begin
      if (mdDoneE) doneSeen++;
      tick();
    end
    chk({tag, " noDonePulse"}, 32'(doneSeen), 32'd0);
    chk({tag, " hiKept"}, hiOut, useReset ? 32'h0 : 32'h0000_1234);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003};
    vecs[6]  = '{2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[10] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    rst = 1'b1; startE = 1'b0; mdOpE = 2'b00; srcAE = '0; srcBE = '0;
    cancelE = 1'b0; mthiE = 1'b0; mtloE = 1'b0; wdataE = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset hi", hiOut, 32'h0);
    chk("reset lo", loOut, 32'h0);
    chk("reset stall", 32'(stallMD), 32'd0);
    chk("reset done", 32'(mdDoneE), 32'd0);
    tick();

    for (int i = 0; i < 11; i++) runVec(vecs[i], i);

    abortSeq(1'b0);
    // The sequencer must be idle and usable right after a cancel
    runVec(vecs[5], 100);
    abortSeq(1'b1);
    runVec(vecs[1], 101);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
